// File: rtl/and_gate.sv
// and_gate: two-input AND cell with a clocked activity monitor on its output.
//
// O is the purely combinational AND of A and B; it does not depend on the
// clock or on reset. The monitor samples O on every rising edge of clk.
//
// Ports
//   clk       in   monitor clock, rising edge
//   rst       in   asynchronous active-high reset of all monitor state
//   A, B      in   operands
//   clr       in   synchronous clear of hi_cnt, rise_cnt and sticky_hi
//   O         out  A & B, combinational
//   O_q       out  O registered
//   O_rise    out  one-cycle pulse on a sampled 0->1 transition of O
//   O_fall    out  one-cycle pulse on a sampled 1->0 transition of O
//   hi_cnt    out  saturating count of edges that sampled O high
//   rise_cnt  out  saturating count of sampled 0->1 transitions
//   sticky_hi out  set once O is sampled high, held until clr or rst
module and_gate #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             A,
  input  logic             B,
  input  logic             clr,
  output logic             O,
  output logic             O_q,
  output logic             O_rise,
  output logic             O_fall,
  output logic [CNT_W-1:0] hi_cnt,
  output logic [CNT_W-1:0] rise_cnt,
  output logic             sticky_hi
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             o_q,       o_d;
  logic             rise_q,    rise_d;
  logic             fall_q,    fall_d;
  logic [CNT_W-1:0] hi_cnt_q,  hi_cnt_d;
  logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d;
  logic             sticky_q,  sticky_d;

  // Sample s and previous registered value p.
  logic s, p, s_rise;

  assign O = A & B;

  always_comb begin
    s      = O;
    p      = o_q;
    s_rise = s & ~p;

    // Edge detection is independent of clr.
    o_d    = s;
    rise_d = s_rise;
    fall_d = ~s & p;

    hi_cnt_d   = hi_cnt_q;
    rise_cnt_d = rise_cnt_q;
    sticky_d   = sticky_q;

    if (clr) begin
      // clr wins over any increment in the same cycle.
      hi_cnt_d   = '0;
      rise_cnt_d = '0;
      sticky_d   = 1'b0;
    end else begin
      if (s && (hi_cnt_q != CNT_MAX))
        hi_cnt_d = hi_cnt_q + CNT_ONE;
      if (s_rise && (rise_cnt_q != CNT_MAX))
        rise_cnt_d = rise_cnt_q + CNT_ONE;
      sticky_d = sticky_q | s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_q        <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      hi_cnt_q   <= '0;
      rise_cnt_q <= '0;
      sticky_q   <= 1'b0;
    end else begin
      o_q        <= o_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      hi_cnt_q   <= hi_cnt_d;
      rise_cnt_q <= rise_cnt_d;
      sticky_q   <= sticky_d;
    end
  end

  assign O_q       = o_q;
  assign O_rise    = rise_q;
  assign O_fall    = fall_q;
  assign hi_cnt    = hi_cnt_q;
  assign rise_cnt  = rise_cnt_q;
  assign sticky_hi = sticky_q;

endmodule

// File: tb/tb_and_gate.sv
// Directed bench for and_gate: combinational truth table with the clock
// stopped, a clocked sequence, saturation on a 2-bit counter instance,
// clr against a rising sample, and asynchronous reset mid-operation.
module tb_and_gate;

  logic        clk, clk_run;
  logic        rst, A, B, clr;
  logic        O, O_q, O_rise, O_fall, sticky_hi;
  logic [15:0] hi_cnt, rise_cnt;

  logic        rst2, A2, B2, clr2;
  logic        O2, O_q2, O_rise2, O_fall2, sticky_hi2;
  logic [1:0]  hi_cnt2, rise_cnt2;

  int n_chk, n_fail;

  and_gate #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .clr(clr),
    .O(O), .O_q(O_q), .O_rise(O_rise), .O_fall(O_fall),
    .hi_cnt(hi_cnt), .rise_cnt(rise_cnt), .sticky_hi(sticky_hi)
  );

  and_gate #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst2), .A(A2), .B(B2), .clr(clr2),
    .O(O2), .O_q(O_q2), .O_rise(O_rise2), .O_fall(O_fall2),
    .hi_cnt(hi_cnt2), .rise_cnt(rise_cnt2), .sticky_hi(sticky_hi2)
  );

  initial clk = 1'b0;
  always begin
    #100;
    if (clk_run) clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic a, b, o;
  } tt_vec_t;

  typedef struct {
    logic        a, b;      // applied before the edge
    logic        o;         // combinational O before the edge
    logic        q, rise, fall, sticky;
    logic [15:0] hi, rc;    // after the edge
  } seq_vec_t;

  tt_vec_t  tt  [5];
  seq_vec_t seqv[7];

  initial begin
    // AB = 00, 10, 11, 01, 00
    tt[0] = '{1'b0, 1'b0, 1'b0};
    tt[1] = '{1'b1, 1'b0, 1'b0};
    tt[2] = '{1'b1, 1'b1, 1'b1};
    tt[3] = '{1'b0, 1'b1, 1'b0};
    tt[4] = '{1'b0, 1'b0, 1'b0};

    //          a     b     o     q     rise  fall  stk   hi     rc
    seqv[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
    seqv[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
    seqv[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
    seqv[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'd1, 16'd1};
    seqv[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, 16'd1};
    seqv[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 16'd1};
    seqv[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 16'd1};

    n_chk = 0; n_fail = 0;
    clk_run = 1'b0;
    rst = 1'b0; A = 1'b0; B = 1'b0; clr = 1'b0;
    rst2 = 1'b0; A2 = 1'b0; B2 = 1'b0; clr2 = 1'b0;
    #5;
    rst = 1'b1; rst2 = 1'b1;
    #1;
    chk("rst_O_q", O_q, 1'b0);
    chk("rst_O_rise", O_rise, 1'b0);
    chk("rst_O_fall", O_fall, 1'b0);
    chk("rst_hi_cnt", hi_cnt, 0);
    chk("rst_rise_cnt", rise_cnt, 0);
    chk("rst_sticky", sticky_hi, 1'b0);

    // Truth table, clock stopped; O is checked while rst is still high.
    for (int i = 0; i < 5; i++) begin
      A = tt[i].a; B = tt[i].b;
      #1;
      chk($sformatf("tt%0d_O", i), O, tt[i].o);
      #99;
    end

    // Clocked sequence; reset released before the first edge.
    rst = 1'b0;
    clk_run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      A = seqv[i].a; B = seqv[i].b;
      #1;
      chk($sformatf("seq%0d_O", i), O, seqv[i].o);
      @(posedge clk); #1;
      chk($sformatf("seq%0d_O_q", i), O_q, seqv[i].q);
      chk($sformatf("seq%0d_O_rise", i), O_rise, seqv[i].rise);
      chk($sformatf("seq%0d_O_fall", i), O_fall, seqv[i].fall);
      chk($sformatf("seq%0d_sticky", i), sticky_hi, seqv[i].sticky);
      chk($sformatf("seq%0d_hi_cnt", i), hi_cnt, seqv[i].hi);
      chk($sformatf("seq%0d_rise_cnt", i), rise_cnt, seqv[i].rc);
    end

    // clr on the same edge as a rising sample.
    A = 1'b1; B = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_hi_cnt", hi_cnt, 0);
    chk("clr_rise_cnt", rise_cnt, 0);
    chk("clr_sticky", sticky_hi, 1'b0);
    chk("clr_O_q", O_q, 1'b1);
    chk("clr_O_rise", O_rise, 1'b1);

    // One more high sample: hi_cnt=1, no new rise.
    @(posedge clk); #1;
    chk("hold_hi_cnt", hi_cnt, 1);
    chk("hold_rise_cnt", rise_cnt, 0);
    chk("hold_O_rise", O_rise, 1'b0);
    chk("hold_sticky", sticky_hi, 1'b1);

    // Asynchronous reset between edges.
    #50;
    rst = 1'b1;
    #1;
    chk("arst_O_q", O_q, 1'b0);
    chk("arst_O_rise", O_rise, 1'b0);
    chk("arst_O_fall", O_fall, 1'b0);
    chk("arst_hi_cnt", hi_cnt, 0);
    chk("arst_rise_cnt", rise_cnt, 0);
    chk("arst_sticky", sticky_hi, 1'b0);
    chk("arst_O", O, 1'b1);
    #9;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_O_rise", O_rise, 1'b1);
    chk("rel_rise_cnt", rise_cnt, 1);
    chk("rel_hi_cnt", hi_cnt, 1);
    chk("rel_O_q", O_q, 1'b1);

    // Saturation on the 2-bit instance, AB=11 held for 6 edges.
    A2 = 1'b1; B2 = 1'b1;
    rst2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk($sformatf("sat%0d_hi_cnt", i), hi_cnt2, (i < 3) ? i + 1 : 3);
      chk($sformatf("sat%0d_rise_cnt", i), rise_cnt2, 1);
    end
    chk("sat_sticky", sticky_hi2, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
